ripple_cnt_ctrl: RTL
====================

# ripple_cnt_ctrl

- Sequencer for a WIDTH-bit flip-flop counter: preload, run up or down to a programmable terminal value, then hold for a fixed settle window before publishing a snapshot.
- Sits above the flip-flop/counter library and gives software-style command strobes (load/start/stop) a clean cycle-level handshake.
- The count register is inside the block; a snapshot register and valid flag are presented to downstream logic.

## Interface
- WIDTH, 4, counter width in bits (≥2)
- SETTLE, 2, cycles spent in SETTLE after terminal match (≥1)

- CLK  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- load  in  1  strobe; in IDLE, count ← load_val
- load_val  in  WIDTH  preload value
- start  in  1  strobe; in IDLE, begin counting
- stop  in  1  strobe; in RUN, abort to IDLE
- up  in  1  direction, sampled every RUN cycle (1 = +1, 0 = −1)
- term  in  WIDTH  terminal value, sampled every RUN cycle
- count  out  WIDTH  live count register
- q_out  out  WIDTH  snapshot of count, taken on DONE entry
- valid  out  1  q_out holds a completed result
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse while in DONE
- wrap  out  1  wrap pulse (see Configuration)

## Operation
- States: IDLE, RUN, SETTLE, DONE. All outputs are registered or decoded from state only.
- IDLE:
  - load=1 → count ← load_val; stay IDLE. load has priority over a simultaneous start, which is dropped.
  - start=1 (load=0) → RUN; valid ← 0.
  - stop is ignored.
- RUN, evaluated each edge in priority order:
  - stop=1 → IDLE; count holds its current value; valid stays 0.
  - count == term → SETTLE; count unchanged; settle counter ← SETTLE−1.
  - Otherwise count ← count ± 1 modulo 2^WIDTH: 2^WIDTH−1 → 0 counting up, 0 → 2^WIDTH−1 counting down.
- SETTLE:
  - Lasts exactly SETTLE cycles; count frozen. Then DONE, with q_out ← count and valid ← 1 on the same edge.
- DONE:
  - One cycle; done=1; then IDLE.
- In RUN, SETTLE and DONE, start and load are ignored. stop is ignored outside RUN.
- valid stays 1 until the next accepted start, or until reset.

## Timing
- Reset values: state IDLE; count 0, q_out 0, settle counter 0; valid, busy, done and wrap all 0.
- Reset asserted mid-operation forces these values immediately, independent of CLK. Operation resumes from IDLE on the first rising edge after rstn deasserts.
- Timeline, with start accepted at edge 0:
  - RUN occupies edges 1..k, where k−1 is the number of steps needed for count to reach term.
  - SETTLE is entered at edge k.
  - DONE is entered at edge k+SETTLE.
  - IDLE is entered at edge k+SETTLE+1.
- Total latency from start to done = steps + SETTLE + 1 cycles.
- If count == term at start, steps = 0: SETTLE is entered at edge 1.
- term or up changing mid-RUN takes effect on the next edge. An unreachable term is never hit, so count runs until stop.

## Configuration
- RIPPLE_CTRL_WRAP_FLAG_EN defined:
  - wrap pulses high for one cycle after any RUN edge where count wraps, either 2^WIDTH−1→0 (up) or 0→2^WIDTH−1 (down).
- Not defined:
  - wrap is tied to 0 and no wrap-detect logic is built.
- All other behaviour is identical in both builds.

## Test plan
- WIDTH=4, SETTLE=2. Load 3, term 6, up=1, start at edge 0 → count = 4, 5, 6 at edges 1–3; SETTLE at edge 4; done high after edge 6; q_out=6, valid=1; busy low after edge 7.
- Load 2, term 14, up=0, macro defined → count 1, 0, 15, 14; wrap pulses exactly once, for the 0→15 step; q_out=14.
- Load 5, start, then stop two cycles later → count = 7 held, IDLE, valid=0, done never asserts.
- load and start in the same IDLE cycle with load_val=9 → count=9, state stays IDLE. Then start with term=9 → SETTLE at edge 1, q_out=9.
- rstn pulled low during SETTLE with count=6 → count, q_out, valid, busy and done are 0 immediately. The first start after release counts from 0.
- start and load strobes during RUN and SETTLE → no effect; the sequence completes with the original values.

Source files
------------

// File: rtl/ripple_cnt_ctrl_if.sv
// ripple_cnt_ctrl_if: command strobes in, count/snapshot/status out.
`timescale 1ns/1ps
interface ripple_cnt_ctrl_if #(
   parameter int unsigned WIDTH = 4
);
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             start;
   logic             stop;
   logic             up;
   logic [WIDTH-1:0] term;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] q_out;
   logic             valid;
   logic             busy;
   logic             done;
   logic             wrap;

   // Command source (software side / testbench)
   modport master (
      output load, load_val, start, stop, up, term,
      input  count, q_out, valid, busy, done, wrap
   );

   // Sequencer side
   modport slave (
      input  load, load_val, start, stop, up, term,
      output count, q_out, valid, busy, done, wrap
   );
endinterface

// File: rtl/ripple_cnt_ctrl.sv
// ripple_cnt_ctrl: preload / run up-down to terminal / settle / publish snapshot.
// Optional wrap pulse built when RIPPLE_CTRL_WRAP_FLAG_EN is defined; otherwise wrap is 0.
`timescale 1ns/1ps
module ripple_cnt_ctrl #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned SETTLE = 2
) (
   input logic             CLK,
   input logic             rstn,
   ripple_cnt_ctrl_if.slave bus
);
   localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_SETTLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] q_out_q, q_out_d;
   logic [SW-1:0]    settle_q, settle_d;
   logic             valid_q, valid_d;
   logic             busy_q, done_q;
`ifdef RIPPLE_CTRL_WRAP_FLAG_EN
   logic             wrap_q, wrap_d;
`endif

   // Next-state and datapath updates; everything holds unless a state acts on it
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      q_out_d  = q_out_q;
      settle_d = settle_q;
      valid_d  = valid_q;
`ifdef RIPPLE_CTRL_WRAP_FLAG_EN
      wrap_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            // load wins over a coincident start
            if (bus.load) begin
               count_d = bus.load_val;
            end else if (bus.start) begin
               state_d = S_RUN;
               valid_d = 1'b0;
            end
         end
         S_RUN: begin
            if (bus.stop) begin
               state_d = S_IDLE;
            end else if (count_q == bus.term) begin
               state_d  = S_SETTLE;
               settle_d = SW'(SETTLE - 1);
            end else if (bus.up) begin
               count_d = count_q + WIDTH'(1);
`ifdef RIPPLE_CTRL_WRAP_FLAG_EN
               wrap_d  = &count_q;
`endif
            end else begin
               count_d = count_q - WIDTH'(1);
`ifdef RIPPLE_CTRL_WRAP_FLAG_EN
               wrap_d  = ~|count_q;
`endif
            end
         end
         S_SETTLE: begin
            if (settle_q == '0) begin
               state_d = S_DONE;
               q_out_d = count_q;
               valid_d = 1'b1;
            end else begin
               settle_d = settle_q - SW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, datapath and status registers; busy/done track the next state
   always_ff @(posedge CLK or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         q_out_q  <= '0;
         settle_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         q_out_q  <= q_out_d;
         settle_q <= settle_d;
         valid_q  <= valid_d;
         busy_q   <= (state_d != S_IDLE);
         done_q   <= (state_d == S_DONE);
      end
   end

`ifdef RIPPLE_CTRL_WRAP_FLAG_EN
   // One-cycle pulse after a RUN step that crossed the modulo boundary
   always_ff @(posedge CLK or negedge rstn) begin
      if (!rstn) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end
   assign bus.wrap = wrap_q;
`else
   assign bus.wrap = 1'b0;
`endif

   assign bus.count = count_q;
   assign bus.q_out = q_out_q;
   assign bus.valid = valid_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule
